// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state codes, opcode
// constants, mux/ALU select encodings and the packed control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_IEXEC  = 4'd9,
    ST_IWB    = 4'd10,
    ST_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW)   ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI)   || (op == OP_XORI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state -> control word.
// Only the FETCH strobes (IRWrite/PCWrite) look at the memory-ready input;
// the IEXEC ALU op uses a flag captured by the FSM during DECODE.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_fetch_rdy,
  input  logic       i_iexec_addi,
  output ctrl_t      o_ctrl
);

  // Per-state control outputs; anything not set for a state stays 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_fetch_rdy;
        o_ctrl.pc_write  = i_fetch_rdy;
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMMSH;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_IEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = i_iexec_addi ? ALUOP_ADD : ALUOP_IMM;
      end
      ST_IWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: state register, next-state logic and
// the illegal-opcode pulse; control outputs come from mc_ctrl_decode.
// Optional feature: define INSTR_COUNT_EN to add the InstrCount retire counter.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        Illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0] InstrCount
`endif
);

  state_e r_state;
  state_e w_next_state;
  logic   r_iexec_addi;
  logic   w_fetch_rdy;
  ctrl_t  w_ctrl;
  logic   w_unused_zero;

  // Zero is combined with PCWriteCond in the datapath, not here.
  assign w_unused_zero = Zero;

  // Fetch strobes stay low while reset is held, even if memory reports ready.
  assign w_fetch_rdy = MemReady & Rst;

  // State register; reset may land mid-access and returns straight to FETCH.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= ST_FETCH;
    else      r_state <= w_next_state;
  end

  // Remember in DECODE whether an immediate op is addi, so IEXEC does not
  // depend on Opcode after the decode cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                       r_iexec_addi <= 1'b0;
    else if (r_state == ST_DECODE)  r_iexec_addi <= (Opcode == OP_ADDI);
  end

  // Next-state logic; Opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:  w_next_state = MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Opcode)
          OP_RTYPE:                       w_next_state = ST_EXEC;
          OP_LW, OP_SW:                   w_next_state = ST_MEMADR;
          OP_BEQ:                         w_next_state = ST_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_XORI:                        w_next_state = ST_IEXEC;
          OP_J:                           w_next_state = ST_JUMP;
          default:                        w_next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR: w_next_state = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  w_next_state = MemReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  w_next_state = ST_FETCH;
      ST_MEMWR:  w_next_state = MemReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   w_next_state = ST_RWB;
      ST_RWB:    w_next_state = ST_FETCH;
      ST_BRANCH: w_next_state = ST_FETCH;
      ST_IEXEC:  w_next_state = ST_IWB;
      ST_IWB:    w_next_state = ST_FETCH;
      ST_JUMP:   w_next_state = ST_FETCH;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state      (r_state),
    .i_fetch_rdy  (w_fetch_rdy),
    .i_iexec_addi (r_iexec_addi),
    .o_ctrl       (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign State       = r_state;

  // Unsupported opcode: high for the single DECODE cycle that rejects it.
  assign Illegal = (r_state == ST_DECODE) && !is_legal_op(Opcode);

`ifdef INSTR_COUNT_EN
  logic [15:0] r_instr_count;
  logic        w_retire;

  // An instruction retires when a completing state hands back to FETCH;
  // DECODE -> FETCH (illegal opcode) is deliberately not counted.
  assign w_retire = (w_next_state == ST_FETCH) &&
                    ((r_state == ST_MEMWB)  || (r_state == ST_MEMWR) ||
                     (r_state == ST_RWB)    || (r_state == ST_BRANCH) ||
                     (r_state == ST_IWB)    || (r_state == ST_JUMP));

  // Retired-instruction counter, wrapping naturally at 16 bits.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)          r_instr_count <= 16'd0;
    else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
  end

  assign InstrCount = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-cycle vector table
// (inputs plus expected state) driven through a scoreboard queue, followed by
// hand-written reset and retire-counter sequences.
module tb_multicycle_controller;

  logic        Clk;
  logic        Rst;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic        Illegal;
`ifdef INSTR_COUNT_EN
  logic [15:0] InstrCount;
`endif

  multicycle_controller dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Opcode      (Opcode),
    .Zero        (Zero),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .Illegal     (Illegal)
`ifdef INSTR_COUNT_EN
    ,
    .InstrCount  (InstrCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] word;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks;
  int   n_pass;
  logic last_addi;

  // Packed observation: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  // MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Illegal}
  function automatic logic [16:0] act_word();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            Illegal};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                      6'b001100, 6'b001101, 6'b001110, 6'b000010};
  endfunction

  // Expected controls, written field by field from the state table.
  function automatic logic [16:0] exp_word(input logic [3:0] st, input logic mr,
                                           input logic addi, input logic ill);
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aop, pcs;
    pcw  = ((st == 4'd0) && mr) || (st == 4'd11);
    pcwc = (st == 4'd8);
    iord = (st == 4'd3) || (st == 4'd5);
    mrd  = (st == 4'd0) || (st == 4'd3);
    mwr  = (st == 4'd5);
    irw  = (st == 4'd0) && mr;
    m2r  = (st == 4'd4);
    rdst = (st == 4'd7);
    rwr  = st inside {4'd4, 4'd7, 4'd10};
    srca = st inside {4'd2, 4'd6, 4'd8, 4'd9};
    srcb = (st == 4'd0) ? 2'b01 :
           (st == 4'd1) ? 2'b11 :
           (st inside {4'd2, 4'd9}) ? 2'b10 : 2'b00;
    aop  = (st == 4'd6) ? 2'b10 :
           (st == 4'd8) ? 2'b01 :
           ((st == 4'd9) && !addi) ? 2'b11 : 2'b00;
    pcs  = (st == 4'd8) ? 2'b01 : (st == 4'd11) ? 2'b10 : 2'b00;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop,
            pcs, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st);
    vec_t v;
    v.op = op; v.zero = z; v.mr = mr; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t e;
    n_checks  = 0;
    n_pass    = 0;
    last_addi = 1'b0;

    // R-type, with a FETCH stall first and junk opcodes outside DECODE
    add(6'b111111, 0, 0, 4'd0);
    add(6'b000000, 0, 1, 4'd0);
    add(6'b000000, 0, 1, 4'd1);
    add(6'b000010, 0, 1, 4'd6);
    add(6'b000100, 0, 1, 4'd7);
    // lw with two MemReady-low cycles in MEMRD
    add(6'b100011, 0, 1, 4'd0);
    add(6'b100011, 0, 1, 4'd1);
    add(6'b100011, 0, 1, 4'd2);
    add(6'b101011, 0, 0, 4'd3);
    add(6'b101011, 0, 0, 4'd3);
    add(6'b100011, 0, 1, 4'd3);
    add(6'b100011, 0, 1, 4'd4);
    // sw with one wait cycle
    add(6'b101011, 0, 1, 4'd0);
    add(6'b101011, 0, 1, 4'd1);
    add(6'b101011, 0, 1, 4'd2);
    add(6'b101011, 0, 0, 4'd5);
    add(6'b101011, 0, 1, 4'd5);
    // beq taken and not taken
    add(6'b000100, 1, 1, 4'd0);
    add(6'b000100, 1, 1, 4'd1);
    add(6'b000100, 1, 1, 4'd8);
    add(6'b000100, 0, 1, 4'd0);
    add(6'b000100, 0, 1, 4'd1);
    add(6'b000100, 0, 1, 4'd8);
    // j
    add(6'b000010, 0, 1, 4'd0);
    add(6'b000010, 0, 1, 4'd1);
    add(6'b000010, 0, 1, 4'd11);
    // addi (opcode changes to ori in IEXEC must not matter)
    add(6'b001000, 0, 1, 4'd0);
    add(6'b001000, 0, 1, 4'd1);
    add(6'b001101, 0, 1, 4'd9);
    add(6'b001101, 0, 1, 4'd10);
    // ori (opcode changes to addi in IEXEC must not matter)
    add(6'b001101, 0, 1, 4'd0);
    add(6'b001101, 0, 1, 4'd1);
    add(6'b001000, 0, 1, 4'd9);
    add(6'b001000, 0, 1, 4'd10);
    // xori
    add(6'b001110, 0, 1, 4'd0);
    add(6'b001110, 0, 1, 4'd1);
    add(6'b001110, 0, 1, 4'd9);
    add(6'b001110, 0, 1, 4'd10);
    // illegal opcodes back to back
    add(6'b111111, 0, 1, 4'd0);
    add(6'b111111, 0, 1, 4'd1);
    add(6'b111111, 0, 1, 4'd0);
    add(6'b000001, 0, 1, 4'd1);
    add(6'b000000, 0, 0, 4'd0);

    // Reset state, MemReady high: fetch strobes must stay low
    Rst = 1'b0; Opcode = 6'b000000; Zero = 1'b0; MemReady = 1'b1;
    #12;
    check("reset_state", {28'd0, State}, 32'd0);
    check("reset_ctrl", {15'd0, act_word()}, {15'd0, exp_word(4'd0, 1'b0, 1'b0, 1'b0)});
    MemReady = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge Clk);
      #1;
      Opcode   = tbl[i].op;
      Zero     = tbl[i].zero;
      MemReady = tbl[i].mr;
      if (tbl[i].st == 4'd1) last_addi = (tbl[i].op == 6'b001000);
      e.st   = tbl[i].st;
      e.word = exp_word(tbl[i].st, tbl[i].mr, last_addi,
                        (tbl[i].st == 4'd1) && !legal(tbl[i].op));
      sb.push_back(e);
      @(negedge Clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_state", i), {28'd0, State}, {28'd0, e.st});
      check($sformatf("vec%0d_ctrl", i), {15'd0, act_word()}, {15'd0, e.word});
    end

    // Asynchronous reset in the middle of a stalled sw
    Opcode = 6'b101011; MemReady = 1'b1;
    @(posedge Clk); #1;
    check("sw_decode", {28'd0, State}, 32'd1);
    @(posedge Clk); #1;
    MemReady = 1'b0;
    @(posedge Clk); #1;
    check("sw_memwr", {28'd0, State}, 32'd5);
    check("sw_memwrite", {31'd0, MemWrite}, 32'd1);
    MemReady = 1'b1;
    #2;
    Rst = 1'b0;
    #1;
    check("async_rst_state", {28'd0, State}, 32'd0);
    check("async_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("async_rst_irwrite", {31'd0, IRWrite}, 32'd0);
    check("async_rst_pcwrite", {31'd0, PCWrite}, 32'd0);
    @(negedge Clk);
    Opcode = 6'b000010;
    Rst = 1'b1;
    #1;
    check("post_rst_irwrite", {31'd0, IRWrite}, 32'd1);
`ifdef INSTR_COUNT_EN
    check("post_rst_count", {16'd0, InstrCount}, 32'd0);
`endif
    @(posedge Clk); #1;
    check("post_rst_decode", {28'd0, State}, 32'd1);

`ifdef INSTR_COUNT_EN
    force dut.r_instr_count = 16'hFFFF;
    #1;
    release dut.r_instr_count;
`endif
    @(posedge Clk); #1;
    check("j_state", {28'd0, State}, 32'd11);
    @(posedge Clk); #1;
    check("j_done", {28'd0, State}, 32'd0);
`ifdef INSTR_COUNT_EN
    check("count_wrap", {16'd0, InstrCount}, 32'd0);
    Opcode = 6'b111111;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("illegal_back_fetch", {28'd0, State}, 32'd0);
    check("count_illegal", {16'd0, InstrCount}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
